// File: rtl/pw_pkg.sv
// Shared definitions for the password-lock attempt controller.
package pw_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_OPEN    = 2'd3
  } pw_state_t;

  // Number of cycles pw_fsm is held in reset after a wrong attempt.
  localparam int unsigned CLEAR_HOLD = 2;

endpackage

// File: rtl/pw_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press pulse on each accepted 0->1 transition.
module pw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Synchronize, count disagreeing samples, flip the accepted level at the terminal count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_cnt == CNT_TERM) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
        r_press <= ~r_level;
      end else begin
        r_press <= 1'b0;
        if (r_sync2 != r_level) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/pw_attempt_ctrl.sv
// Attempt controller between the enter button and pw_fsm: forwards debounced
// presses, clears pw_fsm after wrong attempts, and enforces a timed lockout
// after MAX_FAILS consecutive failures.
module pw_attempt_ctrl
  import pw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 100_000_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               btn_enter,
  input  logic                               fsm_open,
  input  logic                               fsm_wrong,
  output logic                               fsm_enter,
  output logic                               fsm_reset_n,
  output logic                               locked_out,
  output logic                               unlocked,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    HOLD_LAST  = 2'(CLEAR_HOLD - 1);

  pw_state_t     r_state;
  pw_state_t     w_state_next;
  logic [FW-1:0] r_fail_count;
  logic [FW-1:0] w_fail_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [1:0]    r_hold;
  logic [1:0]    w_hold_next;

  logic r_wrong_q, r_wrong_d, r_wrong_rise;
  logic r_open_q, r_open_d, r_open_rise;
  logic r_fsm_enter, r_fsm_reset_n, r_locked_out, r_unlocked;
  logic w_press;

  pw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk   (clk),
    .i_reset (reset),
    .i_btn   (btn_enter),
    .o_press (w_press)
  );

  // Register the pw_fsm flags and register their rising edges; this pipeline
  // sets the two-cycle reaction from flag edge to state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrong_q    <= 1'b0;
      r_wrong_d    <= 1'b0;
      r_wrong_rise <= 1'b0;
      r_open_q     <= 1'b0;
      r_open_d     <= 1'b0;
      r_open_rise  <= 1'b0;
    end else begin
      r_wrong_q    <= fsm_wrong;
      r_wrong_d    <= r_wrong_q;
      r_wrong_rise <= r_wrong_q & ~r_wrong_d;
      r_open_q     <= fsm_open;
      r_open_d     <= r_open_q;
      r_open_rise  <= r_open_q & ~r_open_d;
    end
  end

  // State register with failure count, lockout timer and CLEAR hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_fail_count <= '0;
      r_timer      <= '0;
      r_hold       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fail_count <= w_fail_next;
      r_timer      <= w_timer_next;
      r_hold       <= w_hold_next;
    end
  end

  // Next-state logic; a wrong edge wins over a simultaneous open edge.
  always_comb begin
    w_state_next = r_state;
    w_fail_next  = r_fail_count;
    w_timer_next = r_timer;
    w_hold_next  = r_hold;
    case (r_state)
      ST_CLEAR: begin
        if (r_hold == HOLD_LAST) begin
          w_state_next = ST_ARMED;
          w_hold_next  = '0;
        end else begin
          w_hold_next = r_hold + 1'b1;
        end
      end
      ST_ARMED: begin
        if (r_wrong_rise) begin
          if (r_fail_count + 1'b1 == FAIL_MAX) begin
            w_state_next = ST_LOCKOUT;
            w_fail_next  = FAIL_MAX;
            w_timer_next = TIMER_LOAD;
          end else begin
            w_state_next = ST_CLEAR;
            w_fail_next  = r_fail_count + 1'b1;
            w_hold_next  = '0;
          end
        end else if (r_open_rise) begin
          w_state_next = ST_OPEN;
          w_fail_next  = '0;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_next = ST_ARMED;
          w_fail_next  = '0;
        end else begin
          w_timer_next = r_timer - 1'b1;
        end
      end
      ST_OPEN: begin
        w_state_next = ST_OPEN;
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm_enter   <= 1'b0;
      r_fsm_reset_n <= 1'b0;
      r_locked_out  <= 1'b0;
      r_unlocked    <= 1'b0;
    end else begin
      r_fsm_enter   <= (r_state == ST_ARMED) & w_press;
      r_fsm_reset_n <= (w_state_next == ST_ARMED) | (w_state_next == ST_OPEN);
      r_locked_out  <= (w_state_next == ST_LOCKOUT);
      r_unlocked    <= (w_state_next == ST_OPEN);
    end
  end

  assign fsm_enter   = r_fsm_enter;
  assign fsm_reset_n = r_fsm_reset_n;
  assign locked_out  = r_locked_out;
  assign unlocked    = r_unlocked;
  assign fail_count  = r_fail_count;

endmodule

// File: tb/tb_pw_attempt_ctrl.sv
// Directed bench for pw_attempt_ctrl with a scoreboard of expected enter pulses.
module tb_pw_attempt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_enter;
  logic       fsm_open;
  logic       fsm_wrong;
  logic       fsm_enter;
  logic       fsm_reset_n;
  logic       locked_out;
  logic       unlocked;
  logic [1:0] fail_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_q[$];

  pw_attempt_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MAX_FAILS(3),
    .LOCKOUT_CYCLES(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_enter   (btn_enter),
    .fsm_open    (fsm_open),
    .fsm_wrong   (fsm_wrong),
    .fsm_enter   (fsm_enter),
    .fsm_reset_n (fsm_reset_n),
    .locked_out  (locked_out),
    .unlocked    (unlocked),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed enter pulse must match the oldest expected pulse cycle.
  always @(negedge clk) begin
    if (fsm_enter === 1'b1) begin
      int e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      n_cmp++;
      assert (cyc === e) else begin
        n_fail++;
        $error("FAIL enter_pulse obs_cycle=%0d exp_cycle=%0d", cyc, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Press held long enough to debounce; pulse expected 7 cycles after first sample.
  task automatic press(input bit forwarded);
    btn_enter = 1'b1;
    if (forwarded) exp_q.push_back(cyc + 8);
    tick(10);
    btn_enter = 1'b0;
    tick(10);
  endtask

  // One-cycle wrong pulse that should not cause lockout.
  task automatic wrong_pulse(input int exp_fail);
    fsm_wrong = 1'b1;
    tick(1);
    fsm_wrong = 1'b0;
    tick(1);
    check("wrong_pre_rstn", fsm_reset_n, 1);
    tick(1);
    check("wrong_fail", fail_count, exp_fail);
    check("wrong_rstn_lo0", fsm_reset_n, 0);
    tick(1);
    check("wrong_rstn_lo1", fsm_reset_n, 0);
    tick(1);
    check("wrong_rstn_hi", fsm_reset_n, 1);
  endtask

  // Third wrong pulse; returns with the DUT in its first lockout cycle.
  task automatic enter_lockout();
    fsm_wrong = 1'b1;
    tick(1);
    fsm_wrong = 1'b0;
    tick(1);
    check("lock_pre", locked_out, 0);
    tick(1);
    check("lock_start", locked_out, 1);
    check("lock_fail", fail_count, 3);
    check("lock_rstn", fsm_reset_n, 0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    btn_enter = 1'b0;
    fsm_open  = 1'b0;
    fsm_wrong = 1'b0;
    tick(3);
    check("rst_rstn", fsm_reset_n, 0);
    check("rst_locked", locked_out, 0);
    check("rst_unlocked", unlocked, 0);
    check("rst_fail", fail_count, 0);
    check("rst_enter", fsm_enter, 0);

    reset = 1'b0;
    tick(1);
    check("rel_rstn_lo", fsm_reset_n, 0);
    tick(1);
    check("rel_rstn_hi", fsm_reset_n, 1);

    // Clean press, release gives no second pulse.
    press(1'b1);
    check("clean_q", exp_q.size(), 0);

    // Bouncing input: never stable for four samples.
    for (int i = 0; i < 6; i++) begin
      btn_enter = (i % 2 == 0);
      tick(2);
    end
    btn_enter = 1'b0;
    tick(12);

    // Two failures.
    wrong_pulse(1);
    wrong_pulse(2);
    check("fail2_locked", locked_out, 0);

    // Lockout with a press held inside the window.
    enter_lockout();
    n = 1;
    btn_enter = 1'b1;
    for (int i = 1; i < 60; i++) begin
      tick(1);
      if (i == 8) btn_enter = 1'b0;
      if (locked_out === 1'b1) n++;
      else break;
    end
    check("lock_len", n, 20);
    check("unlock_fail", fail_count, 0);
    check("unlock_rstn", fsm_reset_n, 1);
    tick(4);
    press(1'b1);
    check("post_lock_q", exp_q.size(), 0);

    // Open after one failure; later presses and flags ignored.
    wrong_pulse(1);
    fsm_open = 1'b1;
    tick(1);
    fsm_open = 1'b0;
    tick(1);
    check("open_pre", unlocked, 0);
    tick(1);
    check("open_unlocked", unlocked, 1);
    check("open_fail", fail_count, 0);
    check("open_rstn", fsm_reset_n, 1);
    press(1'b0);
    fsm_wrong = 1'b1;
    tick(1);
    fsm_wrong = 1'b0;
    tick(4);
    check("open_hold", unlocked, 1);
    check("open_fail_hold", fail_count, 0);

    // Fresh run: simultaneous open and wrong count as a failure.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    check("run2_unlocked", unlocked, 0);
    fsm_wrong = 1'b1;
    fsm_open  = 1'b1;
    tick(1);
    fsm_wrong = 1'b0;
    fsm_open  = 1'b0;
    tick(2);
    check("simul_fail", fail_count, 1);
    check("simul_unlocked", unlocked, 0);
    check("simul_rstn", fsm_reset_n, 0);
    tick(2);
    check("simul_rstn_hi", fsm_reset_n, 1);
    tick(2);
    check("simul_unlocked2", unlocked, 0);

    // Reset at lockout cycle 10.
    wrong_pulse(2);
    enter_lockout();
    tick(9);
    check("mid_lock", locked_out, 1);
    reset = 1'b1;
    tick(1);
    check("mrst_locked", locked_out, 0);
    check("mrst_fail", fail_count, 0);
    check("mrst_rstn", fsm_reset_n, 0);
    reset = 1'b0;
    tick(1);
    check("mrst_rel_lo", fsm_reset_n, 0);
    tick(1);
    check("mrst_rel_hi", fsm_reset_n, 1);
    check("mrst_rel_locked", locked_out, 0);
    press(1'b1);

    tick(5);
    check("final_q", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pw_attempt_ctrl.md
# pw_attempt_ctrl

Attempt controller for the password lock: sits between the raw enter button and `pw_fsm`. It debounces the button into single-cycle enter pulses and clears `pw_fsm` after each wrong attempt. It counts consecutive failures and, after `MAX_FAILS`, holds the lock in a timed lockout during which no entries reach the FSM. Instantiated in the top level on the MMCM output clock, between `btnd` and the `pw_fsm` instance.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples required to accept a button level change; must be ≥1.
- `MAX_FAILS`, 3: consecutive wrong attempts that trigger lockout; must be ≥1.
- `LOCKOUT_CYCLES`, 100_000_000: lockout duration in `clk` cycles; must be ≥1.
- `clk`  in  1  FSM clock (MMCM output).
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `btn_enter`  in  1  raw, asynchronous enter button.
- `fsm_open`  in  1  `pw_fsm` open indication.
- `fsm_wrong`  in  1  `pw_fsm` wrong indication.
- `fsm_enter`  out  1  one-cycle enter pulse to `pw_fsm`.
- `fsm_reset_n`  out  1  active-low reset to `pw_fsm`.
- `locked_out`  out  1  high for the whole lockout.
- `unlocked`  out  1  high after a successful open.
- `fail_count`  out  $clog2(MAX_FAILS+1)  consecutive failures so far.

## Operation
- Input conditioning: `btn_enter` passes through a 2-FF synchronizer.
  - A counter tracks consecutive cycles where the synchronized level differs from the accepted level. Any agreeing sample clears the counter.
  - When the counter reaches `DEBOUNCE_CYCLES`, the accepted level flips and the counter clears.
  - An accepted 0→1 flip produces `press`, one cycle wide.
- `fsm_wrong` and `fsm_open` are edge-detected against registered copies of themselves. Only rising edges act.
- States:
  - CLEAR: `fsm_reset_n`=0. Held exactly 2 cycles, then goes to ARMED.
  - ARMED: `fsm_enter`=`press`.
    - On a rising edge of `fsm_wrong`: if `fail_count`+1 == `MAX_FAILS`, go to LOCKOUT; else increment `fail_count` and go to CLEAR.
    - On a rising edge of `fsm_open` with no wrong edge: clear `fail_count` and go to OPEN.
  - LOCKOUT: `fsm_reset_n`=0, `locked_out`=1, `fail_count` held at `MAX_FAILS`. The timer loads `LOCKOUT_CYCLES-1` on entry and decrements each cycle. When the timer is 0, clear `fail_count` and go to ARMED.
  - OPEN: `unlocked`=1. Presses and both FSM flags are ignored. The state is left only by `reset`.
- Simultaneous rising edges of wrong and open in ARMED count as wrong (fail-safe).
- A `press` in any state other than ARMED is dropped, not queued.
- Debounce runs in every state. A button held through lockout produces no pulse afterwards; a new pulse requires a release followed by a press.
- Reset is taken in any state, including mid-lockout and mid-debounce. Reset values: state CLEAR, `fail_count`=0, timer=0, debounce counter=0, accepted level=0, all edge registers=0, `fsm_enter`=0, `fsm_reset_n`=0, `locked_out`=0, `unlocked`=0.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Press latency: `fsm_enter` pulses exactly `DEBOUNCE_CYCLES`+3 cycles after `btn_enter` is first sampled high, provided it stays high. Pulse width is exactly 1 cycle.
- Wrong reaction: if the rising edge of `fsm_wrong` is sampled at cycle t, the state changes and `fail_count` updates at t+2. `fsm_reset_n` goes low at t+2.
- After reset is released, `fsm_reset_n` stays low 2 more cycles, then goes high.
- `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles. `fsm_reset_n` is low for those cycles and is released on the same cycle `locked_out` falls.
- Counter widths: timer is $clog2(`LOCKOUT_CYCLES`+1) bits; debounce counter is $clog2(`DEBOUNCE_CYCLES`+1) bits. Neither wraps; both stop at their terminal value.

## Structure
- Shared package/header `pw_pkg`: state encoding localparams (CLEAR, ARMED, LOCKOUT, OPEN) and the CLEAR hold length constant (2).
- Sub-module `pw_debounce`: synchronizer, debounce counter and rising-edge `press` output, parameterized by `DEBOUNCE_CYCLES`. It is reusable for `btnc`.
- The top level rewires: `btnd`→`btn_enter`, `fsm_enter`→`pw_fsm.enter`. `pw_fsm.reset_n` is driven by `lock & fsm_reset_n`. `reset` is driven by `~lock`.

## Test plan
Parameters: `DEBOUNCE_CYCLES`=4, `MAX_FAILS`=3, `LOCKOUT_CYCLES`=20.
- Clean press: hold `btn_enter` high 10 cycles → exactly one `fsm_enter` pulse, 7 cycles after the first high sample; release produces no pulse.
- Bounce: toggle `btn_enter` every 2 cycles for 12 cycles, then drop it low → no `fsm_enter` pulse.
- Two failures: pulse `fsm_wrong` twice → `fail_count` reads 1, then 2; each pulse produces a 2-cycle `fsm_reset_n` low window; state returns to ARMED.
- Lockout: a third `fsm_wrong` → `locked_out` high for exactly 20 cycles; presses during that window give no `fsm_enter`; afterwards `fail_count`=0 and the next press is forwarded.
- Open and simultaneous flags:
  - `fsm_open` after one failure → `unlocked`=1, `fail_count`=0, and later presses are ignored.
  - In a separate run, `fsm_open` and `fsm_wrong` rising together → treated as a failure, `unlocked` stays 0.
- Reset mid-lockout: assert `reset` at lockout cycle 10 → the next cycle shows `locked_out`=0, `fail_count`=0, `fsm_reset_n`=0; ARMED is reached 2 cycles after `reset` is released.
